xbar_port_scheduler: RTL and testbench
======================================

Name: xbar_port_scheduler

Overview:
- Per-output-port scheduler for the crossbar.
- Shares one crossbar output among N_IN input requesters using round-robin arbitration.
- Locks the grant for a whole packet (until the last beat), or until a beat-count limit forces re-arbitration.
- Drives the one-hot grant and an encoded select used by the output mux.

Parameters:
N_IN, 4, number of requesting input ports (≥2)
IDX_W, 2, width of grant_idx; must equal ceil(log2(N_IN))
MAX_HOLD, 16, max accepted beats per grant before forced release; 0 disables the limit

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
request  input  N_IN  per-input request; held high while that input has a beat to send
req_last  input  N_IN  per-input flag: current beat is the final beat of the packet
out_ready  input  1  downstream output accepts a beat this cycle
grant  output  N_IN  one-hot grant, registered
grant_idx  output  IDX_W  binary index of granted input (mux select), registered
grant_valid  output  1  high when any grant is active
beat_fire  output  1  combinational: grant_valid & request[grant_idx] & out_ready
hold_expired  output  1  one-cycle registered pulse when the MAX_HOLD limit forces a release

Behaviour:
- Reset (reset=0, asynchronous): grant=0, grant_idx=0, grant_valid=0, hold_expired=0, beat counter=0, rr pointer=0 (input 0 has highest priority), state=IDLE.
- States:
  - IDLE: no grant held.
  - BUSY: grant held by input g = grant_idx.
- Round-robin search:
  - Scan from rr pointer upward, modulo N_IN; the first asserted request wins.
  - On every new grant, rr pointer = (winner+1) mod N_IN.
- IDLE -> BUSY:
  - Trigger: any request bit high at a rising edge.
  - grant, grant_idx and grant_valid update at that edge (1-cycle latency from request to grant).
  - Beat counter cleared.
- BUSY hold: grant stays constant while request[g]=1 and no release condition occurs.
- Beat acceptance: a beat transfers only when beat_fire=1. On each fire the beat counter increments; otherwise it holds.
- Release conditions, evaluated at the rising edge:
  - (a) beat_fire & req_last[g]: normal end of packet.
  - (b) request[g]=0: requester abandons; no beat transfers that cycle.
  - (c) beat_fire & ~req_last[g] & MAX_HOLD≠0 & counter==MAX_HOLD-1: forced release; hold_expired=1 for exactly the next cycle.
- Zero-bubble re-arbitration: on release, the same edge re-arbitrates using the already-advanced rr pointer.
  - The releasing input has lowest priority but may win again if it is the only requester (counter cleared).
  - If no request remains, go to IDLE with grant=0.
- Simultaneous conditions: (a) and (c) in the same cycle count as a normal release; hold_expired stays 0.
- Stall: out_ready=0 holds grant and counter indefinitely; no timeout on stall.
- Request changes on non-granted inputs never affect the current grant.
- grant is always one-hot or zero; grant_idx is meaningful only when grant_valid=1.
- Counter width: clog2(MAX_HOLD+1), saturating is not required because release occurs at the limit.
- Reset asserted mid-packet: all outputs clear immediately, without waiting for a clock edge. After reset deasserts, arbitration restarts from input 0.

Test Plan:
- Single packet release:
  - Stimulus: reset, then request=0001, req_last=0001, out_ready=1.
  - Response: next edge grant=0001, grant_idx=0, beat_fire=1; the following edge grant=0000, grant_valid=0 if request drops.
- Rotation:
  - Stimulus: request=0111 held, req_last=0111, out_ready=1.
  - Response: grant sequence 0001, 0010, 0100, 0001, … with no idle cycles between grants.
- Packet lock:
  - Stimulus: input 0 sends a 4-beat packet (req_last high on beat 4); request=0011 throughout.
  - Response: grant=0001 for exactly 4 fire cycles, then 0010 at the edge after the last beat.
- Stall:
  - Stimulus: grant=0010 active, out_ready=0 for 5 cycles.
  - Response: grant unchanged, beat_fire=0, counter unchanged; resumes when out_ready=1.
- Forced release (MAX_HOLD=4):
  - Stimulus: input 0 never asserts last; request=0011.
  - Response: after 4 fires hold_expired pulses 1 cycle and grant=0010. With request=0001 only, grant returns to 0001 with counter=0.
- Async reset mid-packet:
  - Stimulus: reset=0 while grant=0100.
  - Response: grant=0000 and grant_valid=0 before the next clock edge. After release with request=0101, first grant=0001.

Source files
------------

// File: rtl/xbar_port_scheduler.sv
// -----------------------------------------------------------------------------
// xbar_port_scheduler
//
// Per-output-port scheduler for the crossbar. Several inputs compete for one
// crossbar output. A round-robin arbiter picks the winner. The grant is then
// locked for the whole packet. It is released early only if the requester
// drops its request, or if the beat-count limit is reached.
//
// Parameters:
//   N_IN      number of requesting input ports (>= 2)
//   IDX_W     width of grant_idx; must equal ceil(log2(N_IN))
//   MAX_HOLD  max accepted beats per grant before forced release (0 = no limit)
//
// Ports:
//   clock         rising-edge system clock
//   reset         asynchronous, active-low reset
//   request       per-input request, high while that input has a beat to send
//   req_last      per-input flag: the current beat is the packet's final beat
//   out_ready     downstream accepts a beat this cycle
//   grant         registered one-hot grant (all zero when idle)
//   grant_idx     registered binary index of the granted input (mux select)
//   grant_valid   high while a grant is held
//   beat_fire     combinational: a beat transfers this cycle
//   hold_expired  one-cycle registered pulse after a forced release
// -----------------------------------------------------------------------------
module xbar_port_scheduler #(
  parameter int N_IN     = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_IN-1:0]   request,
  input  logic [N_IN-1:0]   req_last,
  input  logic              out_ready,
  output logic [N_IN-1:0]   grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic              beat_fire,
  output logic              hold_expired
);

  // The counter only needs to reach MAX_HOLD-1, because release happens at
  // the limit. Keep at least one bit so the design still elaborates when the
  // limit is disabled.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_IN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_expired_q, hold_expired_d;

  // Round-robin search result
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 scan;

  // Release decode for the currently held grant
  logic               holder_req;
  logic               holder_last;
  logic               fire;
  logic               rel_last;
  logic               rel_forced;
  logic               rel_any;

  // ---------------------------------------------------------------------------
  // Round-robin search: scan upward from the rr pointer, wrapping modulo N_IN.
  // The pointer already sits one past the last winner. So the releasing input
  // has the lowest priority without any extra masking.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < N_IN; i++) begin
      scan = (int'(rr_q) + i) % N_IN;
      if (!win_found && request[IDX_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat acceptance and release conditions
  // ---------------------------------------------------------------------------
  assign holder_req  = request[grant_idx_q];
  assign holder_last = req_last[grant_idx_q];
  assign fire        = (state_q == ST_BUSY) && holder_req && out_ready;

  assign rel_last    = fire && holder_last;
  // A beat that is both last and at the limit counts as a normal release.
  // Requiring ~holder_last here keeps hold_expired low in that case.
  assign rel_forced  = (MAX_HOLD != 0) && fire && !holder_last &&
                       (cnt_q == CNT_LAST);
  assign rel_any     = (state_q == ST_BUSY) &&
                       (!holder_req || rel_last || rel_forced);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    hold_expired_d = 1'b0;

    // Arbitrate when idle, or on the same edge as a release (zero bubble).
    if ((state_q == ST_IDLE) || rel_any) begin
      hold_expired_d = rel_forced;
      if (win_found) begin
        state_d     = ST_BUSY;
        grant_d     = '0;
        grant_d[win_idx] = 1'b1;
        grant_idx_d = win_idx;
        rr_d        = (win_idx == IDX_TOP) ? '0 : win_idx + 1'b1;
        cnt_d       = '0;
      end else begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
        cnt_d       = '0;
      end
    end else if (fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      grant_idx_q    <= '0;
      rr_q           <= '0;
      cnt_q          <= '0;
      hold_expired_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_idx_q    <= grant_idx_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      hold_expired_q <= hold_expired_d;
    end
  end

  assign grant        = grant_q;
  assign grant_idx    = grant_idx_q;
  assign grant_valid  = (state_q == ST_BUSY);
  assign beat_fire    = fire;
  assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_xbar_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_xbar_port_scheduler
//
// Scoreboard bench for xbar_port_scheduler (N_IN=4, MAX_HOLD=4).
// The stimulus process drives the inputs just after each rising edge. It then
// asks a behavioural reference model for the outputs that cycle should show,
// and queues them. A monitor pops the queue on each falling edge and compares.
// The async reset checks are made directly from the stimulus process.
// -----------------------------------------------------------------------------
module tb_xbar_port_scheduler;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] req_last;
  logic         out_ready;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_valid;
  logic         beat_fire;
  logic         hold_expired;

  xbar_port_scheduler #(.N_IN(N), .IDX_W(2), .MAX_HOLD(MAXH)) dut (
    .clock        (clock),
    .reset        (reset),
    .request      (request),
    .req_last     (req_last),
    .out_ready    (out_ready),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .beat_fire    (beat_fire),
    .hold_expired (hold_expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] grant;
    logic         valid;
    logic [1:0]   idx;
    logic         fire;
    logic         hexp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model state. holder is -1 when no grant is held. beats counts
  // the beats accepted under the current grant.
  int   holder = -1;
  int   rr     = 0;
  int   beats  = 0;
  bit   hexp   = 0;

  // Give the grant to the first requester at or above rr, wrapping.
  task automatic model_arbitrate(input logic [N-1:0] rq);
    holder = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr + k) % N;
      if (holder < 0 && rq[c]) holder = c;
    end
    if (holder >= 0) begin
      rr    = (holder + 1) % N;
      beats = 0;
    end
  endtask

  // Drive one cycle of stimulus. Queue what the DUT should show during this
  // cycle, then advance the model across the coming rising edge.
  task automatic drive_cycle(input logic [N-1:0] rq, input logic [N-1:0] lst,
                             input logic rdy);
    exp_t e;
    bit   last_beat, forced;
    @(posedge clock);
    #1;
    request   = rq;
    req_last  = lst;
    out_ready = rdy;
    e.grant = (holder >= 0) ? (4'b0001 << holder) : 4'b0000;
    e.valid = (holder >= 0);
    e.idx   = (holder >= 0) ? 2'(holder) : 2'd0;
    e.fire  = (holder >= 0) && rq[holder] && rdy;
    e.hexp  = hexp;
    exp_q.push_back(e);

    hexp = 0;
    if (holder < 0) begin
      model_arbitrate(rq);
    end else begin
      last_beat = e.fire && lst[holder];
      forced    = e.fire && !last_beat && (beats + 1 == MAXH);
      if (!rq[holder] || last_beat || forced) begin
        hexp = forced;
        model_arbitrate(rq);
      end else if (e.fire) begin
        beats++;
      end
    end
  endtask

  // Assert reset between clock edges. The outputs must clear at once, before
  // the next clock edge arrives.
  task automatic async_reset_check();
    @(posedge clock);
    #3;
    vectors++;
    if (grant !== ((holder >= 0) ? (4'b0001 << holder) : 4'b0000)) begin
      miscompares++;
      $display("FAIL pre_reset_grant: got %b expected %b", grant,
               (holder >= 0) ? (4'b0001 << holder) : 4'b0000);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || hold_expired !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_clear: got grant=%b valid=%b hexp=%b expected 0000/0/0",
               grant, grant_valid, hold_expired);
    end else begin
      $display("async reset: outputs cleared before next edge");
    end
    request  = '0;
    req_last = '0;
    holder = -1; rr = 0; beats = 0; hexp = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (grant !== e.grant || grant_valid !== e.valid ||
            (e.valid && grant_idx !== e.idx) || beat_fire !== e.fire ||
            hold_expired !== e.hexp) begin
          miscompares++;
          $display("FAIL cycle_outputs @%0t: got grant=%b valid=%b idx=%0d fire=%b hexp=%b expected grant=%b valid=%b idx=%0d fire=%b hexp=%b",
                   $time, grant, grant_valid, grant_idx, beat_fire, hold_expired,
                   e.grant, e.valid, e.idx, e.fire, e.hexp);
        end else begin
          $display("t=%0t req=%b last=%b rdy=%b grant=%b fire=%b hexp=%b",
                   $time, request, req_last, out_ready, grant, beat_fire,
                   hold_expired);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    request   = '0;
    req_last  = '0;
    out_ready = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || hold_expired !== 1'b0 ||
        beat_fire !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got grant=%b valid=%b hexp=%b fire=%b expected all zero",
               grant, grant_valid, hold_expired, beat_fire);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Single packet, then the request drops.
    drive_cycle(4'b0001, 4'b0001, 1'b1);
    drive_cycle(4'b0001, 4'b0001, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);

    // Rotation among three single-beat requesters.
    repeat (8) drive_cycle(4'b0111, 4'b0111, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);

    // Packet lock: 4-beat packet from input 0. Its last beat also hits
    // MAX_HOLD, so this must count as a normal release.
    drive_cycle(4'b0011, 4'b0000, 1'b1);
    drive_cycle(4'b0011, 4'b0000, 1'b1);
    drive_cycle(4'b0011, 4'b0000, 1'b1);
    drive_cycle(4'b0011, 4'b0000, 1'b1);
    drive_cycle(4'b0011, 4'b0001, 1'b1);
    drive_cycle(4'b0010, 4'b0000, 1'b1);

    // Stall: input 1 holds the grant while out_ready is low.
    repeat (5) drive_cycle(4'b0010, 4'b0000, 1'b0);
    drive_cycle(4'b0010, 4'b0010, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);

    // Forced release: input 0 never asserts last.
    repeat (7) drive_cycle(4'b0011, 4'b0000, 1'b1);
    repeat (7) drive_cycle(4'b0001, 4'b0000, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);

    // Async reset while input 2 holds a stalled grant, then restart from 0.
    drive_cycle(4'b0100, 4'b0000, 1'b0);
    drive_cycle(4'b0100, 4'b0000, 1'b0);
    async_reset_check();
    drive_cycle(4'b0101, 4'b0000, 1'b1);
    drive_cycle(4'b0101, 4'b0101, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1);

    // Randomised traffic
    for (int t = 0; t < 2000; t++) begin
      logic [N-1:0] rq, lst;
      logic         rdy;
      rq  = 4'($urandom_range(0, 15));
      lst = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(rq, lst, rdy);
      if (t == 1000) async_reset_check();
    end

    // Drain the scoreboard, with a bound.
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clock);
    @(negedge clock);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
